// File: rtl/parametrik_carpma_birimi_pkg.sv
// carpma_paketi: op-code constants, FSM state encoding and small decode helpers
// shared by the multiplier top and its testbench.
//   IslevMul/IslevMulh/IslevMulhu/IslevMulhsu : one-hot op codes
//   durum_e                                   : FSM states
//   islev_gecerli()                           : legal op-code check
//   isaret_cifti()                            : {a_signed, b_signed} for an op
package carpma_paketi;

  localparam logic [3:0] IslevMul    = 4'h1;
  localparam logic [3:0] IslevMulh   = 4'h2;
  localparam logic [3:0] IslevMulhu  = 4'h4;
  localparam logic [3:0] IslevMulhsu = 4'h8;

  typedef enum logic [1:0] {
    StBosta   = 2'd0,
    StHesapla = 2'd1,
    StBitti   = 2'd2
  } durum_e;

  function automatic logic islev_gecerli(input logic [3:0] kod);
    return (kod == IslevMul) || (kod == IslevMulh) || (kod == IslevMulhu) ||
           (kod == IslevMulhsu);
  endfunction

  // Bit 1: multiplicand signed, bit 0: multiplier signed.
  function automatic logic [1:0] isaret_cifti(input logic [3:0] kod);
    return {kod != IslevMulhu, (kod == IslevMul) || (kod == IslevMulh)};
  endfunction

endpackage

// File: rtl/parametrik_carpma_birimi_if.sv
// Request/response bundle of the multiplier.
//   master : requester side (drives op, operands, valid, flush)
//   slave  : multiplier side (drives busy, done pulse, result)
interface parametrik_carpma_birimi_if #(
  parameter int unsigned VERI_GENISLIGI = 32
);
  logic [3:0]                islev_kodu_g;
  logic [VERI_GENISLIGI-1:0] islec1_g;
  logic [VERI_GENISLIGI-1:0] islec2_g;
  logic                      hazir_g;
  logic                      iptal_g;
  logic                      mesgul_c;
  logic                      bitti_c;
  logic [VERI_GENISLIGI-1:0] sonuc_c;

  modport master (
    output islev_kodu_g, islec1_g, islec2_g, hazir_g, iptal_g,
    input  mesgul_c, bitti_c, sonuc_c
  );

  modport slave (
    input  islev_kodu_g, islec1_g, islec2_g, hazir_g, iptal_g,
    output mesgul_c, bitti_c, sonuc_c
  );
endinterface

// File: rtl/parametrik_carpma_birimi_carpim_adimi.sv
// carpim_adimi: one combinational radix-2^S step of the shift-add multiplier.
//   i_birikim  : running 2W-bit accumulator
//   i_carpilan : multiplicand, already extended to 2W and shifted to this digit
//   i_hane     : S multiplier bits retired this step
//   i_duzelt   : last step of a signed multiplier with its sign bit set
//   o_birikim  : updated accumulator (mod 2^2W)
module carpim_adimi #(
  parameter int unsigned VERI_GENISLIGI = 32,
  parameter int unsigned ADIM_BITI      = 2
) (
  input  logic [2*VERI_GENISLIGI-1:0] i_birikim,
  input  logic [2*VERI_GENISLIGI-1:0] i_carpilan,
  input  logic [ADIM_BITI-1:0]        i_hane,
  input  logic                        i_duzelt,
  output logic [2*VERI_GENISLIGI-1:0] o_birikim
);

  logic [2*VERI_GENISLIGI-1:0] w_toplam;

  always_comb begin
    w_toplam = i_birikim;
    for (int j = 0; j < int'(ADIM_BITI); j++) begin
      if (i_hane[j]) w_toplam = w_toplam + (i_carpilan << j);
    end
    // The multiplier was consumed as unsigned; a negative one carries an extra
    // -2^W weight, i.e. subtract a_ext << W (= current multiplicand << S).
    if (i_duzelt) w_toplam = w_toplam - (i_carpilan << ADIM_BITI);
  end

  assign o_birikim = w_toplam;

endmodule

// File: rtl/parametrik_carpma_birimi.sv
// parametrik_carpma_birimi: iterative MUL/MULH/MULHU/MULHSU unit retiring S
// multiplier bits per cycle, with a one-entry product cache so that a repeat
// of the last operands and signedness completes in one cycle.
//   clk_g, rst_g : clock, synchronous active-low reset
//   bus (slave)  : op, operands, valid, flush in; busy, done pulse, result out
module parametrik_carpma_birimi
  import carpma_paketi::*;
#(
  parameter int unsigned VERI_GENISLIGI = 32,
  parameter int unsigned ADIM_BITI      = 2
) (
  input  logic                        clk_g,
  input  logic                        rst_g,
  parametrik_carpma_birimi_if.slave   bus
);

  localparam int unsigned W          = VERI_GENISLIGI;
  localparam int unsigned S          = ADIM_BITI;
  localparam int unsigned AdimSayisi = W / S;
  localparam int unsigned SayacGen   = $clog2(AdimSayisi + 1);

  durum_e              r_durum, w_durum_sonraki;
  logic [2*W-1:0]      r_birikim, r_carpilan, w_birikim_sonraki, w_a_genis;
  logic [W-1:0]        r_carpan, r_a, r_b, r_sonuc;
  logic [SayacGen-1:0] r_sayac;
  logic [1:0]          r_isaret, w_isaret_yeni;
  logic [3:0]          r_islev;
  logic                r_gecerli;
  logic                w_kabul, w_isabet, w_son_adim, w_duzelt, w_mesgul, w_bitti;

  function automatic logic [W-1:0] sonuc_sec(input logic [2*W-1:0] carpim,
                                             input logic [3:0]     kod);
    return (kod == IslevMul) ? carpim[W-1:0] : carpim[2*W-1:W];
  endfunction

  assign w_isaret_yeni = isaret_cifti(bus.islev_kodu_g);
  assign w_kabul       = bus.hazir_g && !bus.iptal_g && (r_durum != StHesapla) &&
                         islev_gecerli(bus.islev_kodu_g);
  // r_birikim holds the last finished product while r_gecerli is set.
  assign w_isabet      = r_gecerli && (bus.islec1_g == r_a) && (bus.islec2_g == r_b) &&
                         (w_isaret_yeni == r_isaret);
  assign w_a_genis     = {{W{w_isaret_yeni[1] & bus.islec1_g[W-1]}}, bus.islec1_g};
  assign w_son_adim    = (r_sayac == SayacGen'(1));
  assign w_duzelt      = w_son_adim && r_isaret[0] && r_b[W-1];

  carpim_adimi #(
    .VERI_GENISLIGI (W),
    .ADIM_BITI      (S)
  ) u_carpim_adimi (
    .i_birikim  (r_birikim),
    .i_carpilan (r_carpilan),
    .i_hane     (r_carpan[S-1:0]),
    .i_duzelt   (w_duzelt),
    .o_birikim  (w_birikim_sonraki)
  );

  // State register.
  always_ff @(posedge clk_g) begin
    if (!rst_g) r_durum <= StBosta;
    else        r_durum <= w_durum_sonraki;
  end

  // Next state.
  always_comb begin
    w_durum_sonraki = r_durum;
    unique case (r_durum)
      StBosta, StBitti: begin
        if (w_kabul) w_durum_sonraki = w_isabet ? StBitti : StHesapla;
        else         w_durum_sonraki = StBosta;
      end
      StHesapla: begin
        if (bus.iptal_g)     w_durum_sonraki = StBosta;
        else if (w_son_adim) w_durum_sonraki = StBitti;
      end
      default: w_durum_sonraki = StBosta;
    endcase
  end

  // Outputs.
  always_comb begin
    w_mesgul = 1'b0;
    w_bitti  = 1'b0;
    unique case (r_durum)
      StHesapla: w_mesgul = 1'b1;
      StBitti:   w_bitti  = 1'b1;
      default: ;
    endcase
  end

  assign bus.mesgul_c = w_mesgul;
  assign bus.bitti_c  = w_bitti;
  assign bus.sonuc_c  = r_sonuc;

  // Datapath.
  always_ff @(posedge clk_g) begin
    if (!rst_g) begin
      r_birikim  <= '0;
      r_carpilan <= '0;
      r_carpan   <= '0;
      r_sayac    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_isaret   <= '0;
      r_islev    <= '0;
      r_gecerli  <= 1'b0;
      r_sonuc    <= '0;
    end else if (w_kabul) begin
      r_islev <= bus.islev_kodu_g;
      if (w_isabet) begin
        r_sonuc <= sonuc_sec(r_birikim, bus.islev_kodu_g);
      end else begin
        r_a        <= bus.islec1_g;
        r_b        <= bus.islec2_g;
        r_isaret   <= w_isaret_yeni;
        r_gecerli  <= 1'b0;
        r_birikim  <= '0;
        r_carpilan <= w_a_genis;
        r_carpan   <= bus.islec2_g;
        r_sayac    <= SayacGen'(AdimSayisi);
      end
    end else if (r_durum == StHesapla) begin
      if (bus.iptal_g) begin
        r_gecerli <= 1'b0;
      end else begin
        r_birikim  <= w_birikim_sonraki;
        r_carpilan <= r_carpilan << S;
        r_carpan   <= r_carpan >> S;
        r_sayac    <= r_sayac - SayacGen'(1);
        if (w_son_adim) begin
          r_sonuc   <= sonuc_sec(w_birikim_sonraki, r_islev);
          r_gecerli <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/parametrik_carpma_birimi.md
PARAMETRIK_CARPMA_BIRIMI -- requirements
Module: parametrik_carpma_birimi

Interface
REQ-001 SHALL have parameter VERI_GENISLIGI, default 32, operand/result width W; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter ADIM_BITI, default 2, multiplier bits retired per cycle S; legal values 1, 2, 4; W mod S = 0.
REQ-003 SHALL have port clk_g  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_g  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port islev_kodu_g  input  4  one-hot op: 0x1 MUL, 0x2 MULH, 0x4 MULHU, 0x8 MULHSU.
REQ-006 SHALL have port islec1_g  input  W  multiplicand a.
REQ-007 SHALL have port islec2_g  input  W  multiplier b.
REQ-008 SHALL have port hazir_g  input  1  request valid.
REQ-009 SHALL have port iptal_g  input  1  flush; abort in-flight op.
REQ-010 SHALL have port mesgul_c  output  1  busy; request not accepted while high.
REQ-011 SHALL have port bitti_c  output  1  one-cycle completion pulse.
REQ-012 SHALL have port sonuc_c  output  W  result; held stable until next bitti_c.

Function
REQ-013 SHALL accept a request on an edge where hazir_g=1, iptal_g=0, mesgul_c=0 and islev_kodu_g is one of the four legal codes; illegal codes SHALL be ignored (no acceptance, no bitti_c).
REQ-014 SHALL register islev, a, b on acceptance; later input changes SHALL not affect the op.
REQ-015 SHALL implement FSM BOSTA, HESAPLA, BITTI: BOSTA->HESAPLA on accept; HESAPLA stays N=W/S cycles then ->BITTI; BITTI->HESAPLA on new accept, else ->BOSTA.
REQ-016 SHALL drive mesgul_c=1 exactly in HESAPLA; bitti_c=1 exactly in BITTI.
REQ-017 SHALL assert bitti_c N+1 cycles after the accepting edge (W=32, S=2: 17 cycles).
REQ-018 SHALL treat a signed for MUL, MULH, MULHSU; b signed for MUL, MULH; else unsigned.
REQ-019 SHALL compute the exact 2W-bit two's-complement product; MUL returns bits [W-1:0], others bits [2W-1:W].
REQ-020 SHALL retain the last completed 2W-bit product plus its a, b and signedness pair.
REQ-021 SHALL, when an accepted request matches the retained a, b and signedness (e.g. MULH after MUL on same operands), skip HESAPLA, go directly to BITTI, and assert bitti_c 1 cycle after acceptance.
REQ-022 SHALL on iptal_g=1 in HESAPLA go to BOSTA next cycle, suppress bitti_c, keep sonuc_c unchanged, invalidate the retained product.
REQ-023 SHALL let iptal_g override hazir_g in the same cycle (no accept); iptal_g in BITTI SHALL not retract that cycle's bitti_c.
REQ-024 SHALL handle boundary operands exactly: a=b=most-negative, all-ones unsigned, zero.

Reset
REQ-025 SHALL on rst_g=0 at a clock edge enter BOSTA, drive mesgul_c=0, bitti_c=0, sonuc_c=0, clear the retained-product valid flag.
REQ-026 SHALL let reset mid-HESAPLA abort without bitti_c; reset SHALL dominate iptal_g and hazir_g.

Structure
REQ-027 SHALL place op-code constants (MUL, MULH, MULHU, MULHSU) and FSM state encodings in shared package carpma_paketi.
REQ-028 SHALL instantiate one sub-module carpim_adimi: combinational S-bit partial-product/accumulate step, parametrised by W and S.
REQ-029 SHALL hold accumulator, shifted multiplier and step counter (width clog2(N+1)) in the top module.

Verification
REQ-030 SHALL test W=32, S=2: MUL a=7, b=-3 -> bitti_c at cycle 17, sonuc_c=0xFFFFFFEB.
REQ-031 SHALL test MULH a=b=0x80000000 -> sonuc_c=0x40000000; then MUL same operands -> bitti_c 1 cycle later, sonuc_c=0x00000000.
REQ-032 SHALL test MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 SHALL test iptal_g at HESAPLA cycle 5 -> no bitti_c, mesgul_c low next cycle, sonuc_c unchanged; retry same op -> full 17-cycle latency.
REQ-034 SHALL test back-to-back: new hazir_g during BITTI accepted, second bitti_c 17 cycles later; hazir_g during HESAPLA ignored.
REQ-035 SHALL test rst_g=0 mid-op and parameter sweep S in {1,4}, W in {8,64} against a reference model with random operands, latency N+1.
